// File: rtl/mnist_pkg.sv
// Shared types and datapath pipeline offsets for the MNIST layer sequencer.
package mnist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DRAIN, ST_RELU, ST_QDQ,
    ST_QWAIT, ST_ROUND, ST_SAT, ST_WRITE, ST_DONE
  } layer_st_e;

  // Cycle offsets between mac pipeline stages
  localparam int MAC2ACC_DLY   = 2;
  localparam int QDQ2ROUND_DLY = 2;
  localparam int ROUND2SAT_DLY = 1;

endpackage

// File: rtl/mac_layer_ctrl_if.sv
// Control/address bundle between the layer sequencer, the top FSM and the mac/BRAMs.
interface mac_layer_ctrl_if #(
  parameter int IMG_AW = 10,
  parameter int W_AW   = 16,
  parameter int O_AW   = 6
);
  logic              start_i;
  logic              relu_cfg_i;
  logic              busy_o;
  logic              done_o;
  logic              img_rd_en_o;
  logic [IMG_AW-1:0] img_addr_o;
  logic              w_rd_en_o;
  logic [W_AW-1:0]   w_addr_o;
  logic              mac_clear_o;
  logic              mac_en_o;
  logic              acc_en_o;
  logic              relu_en_o;
  logic              qdq_en_o;
  logic              round_en_o;
  logic              sat_en_o;
  logic              out_we_o;
  logic [O_AW-1:0]   out_addr_o;

  modport master (
    input  start_i, relu_cfg_i,
    output busy_o, done_o, img_rd_en_o, img_addr_o, w_rd_en_o, w_addr_o,
           mac_clear_o, mac_en_o, acc_en_o, relu_en_o, qdq_en_o,
           round_en_o, sat_en_o, out_we_o, out_addr_o
  );

  modport slave (
    output start_i, relu_cfg_i,
    input  busy_o, done_o, img_rd_en_o, img_addr_o, w_rd_en_o, w_addr_o,
           mac_clear_o, mac_en_o, acc_en_o, relu_en_o, qdq_en_o,
           round_en_o, sat_en_o, out_we_o, out_addr_o
  );
endinterface

// File: rtl/strobe_delay.sv
// Single-bit strobe delay line of DEPTH cycles; DEPTH=0 is a wire.
module strobe_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_sr
    logic [DEPTH-1:0] vld_pipe;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) vld_pipe <= '0;
      else         vld_pipe <= DEPTH'({vld_pipe, d_i});
    end

    assign q_o = vld_pipe[DEPTH-1];
  end

endmodule

// File: rtl/mac_layer_ctrl.sv
// Fully-connected layer sequencer: walks N_OUT neurons over N_IN inputs and
// drives buffer reads, mac stage strobes and the output buffer write.
module mac_layer_ctrl
  import mnist_pkg::*;
#(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 64,
  parameter int RD_LAT = 1,
  parameter int IMG_AW = 10,
  parameter int W_AW   = 16,
  parameter int O_AW   = 6
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  mac_layer_ctrl_if.master bus
);

  localparam logic [IMG_AW-1:0] K_LAST   = IMG_AW'(N_IN - 1);
  localparam logic [O_AW-1:0]   N_LAST   = O_AW'(N_OUT - 1);
  localparam logic [2:0]        DRN_LAST = 3'(RD_LAT + MAC2ACC_DLY - 1);
  localparam logic [2:0]        QW_LAST  = 3'(QDQ2ROUND_DLY - 2);
  localparam logic [2:0]        RND_LAST = 3'(ROUND2SAT_DLY - 1);

  layer_st_e         st;
  logic [IMG_AW-1:0] k_q;
  logic [W_AW-1:0]   w_q;
  logic [O_AW-1:0]   n_q;
  logic [2:0]        cnt;
  logic              relu_cfg_q;
  logic              rd_en_q, clr_q, relu_q, qdq_q, round_q, sat_q, we_q;
  logic              busy_q, done_q;
  logic              mac_en, acc_en;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st         <= ST_IDLE;
      k_q        <= '0;
      w_q        <= '0;
      n_q        <= '0;
      cnt        <= '0;
      relu_cfg_q <= 1'b0;
      rd_en_q    <= 1'b0;
      clr_q      <= 1'b0;
      relu_q     <= 1'b0;
      qdq_q      <= 1'b0;
      round_q    <= 1'b0;
      sat_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (bus.start_i) begin
          st         <= ST_FETCH;
          relu_cfg_q <= bus.relu_cfg_i;
          busy_q     <= 1'b1;
          n_q        <= '0;
          k_q        <= '0;
          w_q        <= '0;
          rd_en_q    <= 1'b1;
          clr_q      <= 1'b1;
        end
        ST_FETCH: begin
          clr_q <= 1'b0;
          if (k_q == K_LAST) begin
            st      <= ST_DRAIN;
            rd_en_q <= 1'b0;
            cnt     <= '0;
          end else begin
            k_q <= k_q + 1'b1;
            w_q <= w_q + 1'b1;
          end
        end
        // Wait until the last product has been accumulated
        ST_DRAIN: begin
          if (cnt == DRN_LAST) begin
            st     <= ST_RELU;
            relu_q <= relu_cfg_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELU: begin
          st     <= ST_QDQ;
          relu_q <= 1'b0;
          qdq_q  <= 1'b1;
        end
        ST_QDQ: begin
          st    <= ST_QWAIT;
          qdq_q <= 1'b0;
          cnt   <= '0;
        end
        ST_QWAIT: begin
          if (cnt == QW_LAST) begin
            st      <= ST_ROUND;
            round_q <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ROUND: begin
          round_q <= 1'b0;
          if (cnt == RND_LAST) begin
            st    <= ST_SAT;
            sat_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAT: begin
          st    <= ST_WRITE;
          sat_q <= 1'b0;
          we_q  <= 1'b1;
        end
        ST_WRITE: begin
          we_q <= 1'b0;
          if (n_q == N_LAST) begin
            st     <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            st      <= ST_FETCH;
            n_q     <= n_q + 1'b1;
            k_q     <= '0;
            w_q     <= w_q + 1'b1;
            rd_en_q <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          st     <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  strobe_delay #(.DEPTH(RD_LAT)) u_rd_dly (
    .clk_i (clk_i), .rstn_i (rstn_i), .d_i (rd_en_q), .q_o (mac_en)
  );

  strobe_delay #(.DEPTH(MAC2ACC_DLY)) u_acc_dly (
    .clk_i (clk_i), .rstn_i (rstn_i), .d_i (mac_en), .q_o (acc_en)
  );

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.img_rd_en_o = rd_en_q;
  assign bus.img_addr_o  = k_q;
  assign bus.w_rd_en_o   = rd_en_q;
  assign bus.w_addr_o    = w_q;
  assign bus.mac_clear_o = clr_q;
  assign bus.mac_en_o    = mac_en;
  assign bus.acc_en_o    = acc_en;
  assign bus.relu_en_o   = relu_q;
  assign bus.qdq_en_o    = qdq_q;
  assign bus.round_en_o  = round_q;
  assign bus.sat_en_o    = sat_q;
  assign bus.out_we_o    = we_q;
  assign bus.out_addr_o  = n_q;

endmodule

// File: tb/tb_mac_layer_ctrl.sv
// Directed bench for mac_layer_ctrl (N_IN=4, N_OUT=2, RD_LAT=1) with a small
// behavioural mac/BRAM model for end-to-end output values.
module tb_mac_layer_ctrl;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_layer_ctrl_if #(.IMG_AW(4), .W_AW(8), .O_AW(2)) bus ();

  mac_layer_ctrl #(
    .N_IN(4), .N_OUT(2), .RD_LAT(1), .IMG_AW(4), .W_AW(8), .O_AW(2)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.master)
  );

  // mac + buffer model: 1-cycle reads, 2-stage multiply, acc, relu, qdq, round, sat
  logic signed [7:0] img_mem [4];
  logic signed [7:0] w_mem   [8];
  logic signed [7:0] omem    [4];
  logic signed [7:0] img_q, w_q, y;
  int                m1, m2, acc;
  longint            mul, rq;

  always @(posedge clk) begin
    if (bus.img_rd_en_o) img_q <= img_mem[bus.img_addr_o[1:0]];
    if (bus.w_rd_en_o)   w_q   <= w_mem[bus.w_addr_o[2:0]];
    if (bus.mac_en_o)    m1    <= int'(img_q) * int'(w_q);
    m2 <= m1;
    if (bus.mac_clear_o)                acc <= 0;
    else if (bus.acc_en_o)              acc <= acc + m2;
    else if (bus.relu_en_o && acc < 0)  acc <= 0;
    if (bus.qdq_en_o)   mul <= longint'(acc) * 37;
    if (bus.round_en_o) rq  <= (mul + 32768) >>> 16;
    if (bus.sat_en_o) begin
      if (rq > 127)       y <= 8'sd127;
      else if (rq < -128) y <= -8'sd128;
      else                y <= rq[7:0];
    end
    if (bus.out_we_o) omem[bus.out_addr_o] <= y;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.busy_o, bus.done_o, bus.img_rd_en_o, bus.img_addr_o,
                bus.w_rd_en_o, bus.w_addr_o, bus.mac_clear_o, bus.mac_en_o,
                bus.acc_en_o, bus.relu_en_o, bus.qdq_en_o, bus.round_en_o,
                bus.sat_en_o, bus.out_we_o, bus.out_addr_o});
  endfunction

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Per-cycle strobe histories, indexed by cycle offset from start acceptance
  logic [63:0] h_rd, h_mac, h_acc, h_relu, h_qdq, h_rnd, h_sat, h_we, h_done, h_busy, h_clr;
  logic [3:0]  ia [64];
  logic [7:0]  wa [64];
  logic [1:0]  oa [64];
  int          viol;

  task automatic sample(input int idx);
    int n1;
    h_rd[idx]   = bus.img_rd_en_o & bus.w_rd_en_o;
    h_mac[idx]  = bus.mac_en_o;
    h_acc[idx]  = bus.acc_en_o;
    h_relu[idx] = bus.relu_en_o;
    h_qdq[idx]  = bus.qdq_en_o;
    h_rnd[idx]  = bus.round_en_o;
    h_sat[idx]  = bus.sat_en_o;
    h_we[idx]   = bus.out_we_o;
    h_done[idx] = bus.done_o;
    h_busy[idx] = bus.busy_o;
    h_clr[idx]  = bus.mac_clear_o;
    ia[idx] = bus.img_addr_o;
    wa[idx] = bus.w_addr_o;
    oa[idx] = bus.out_addr_o;
    n1 = int'(bus.acc_en_o) + int'(bus.relu_en_o) + int'(bus.qdq_en_o) +
         int'(bus.round_en_o) + int'(bus.mac_clear_o);
    if (n1 > 1) viol++;
    if (bus.mac_en_o && bus.qdq_en_o) viol++;
  endtask

  // Start a layer at cycle s and record 40 cycles; optional held start,
  // ignored start pulses at s+5/s+20, or async reset at s+rst_at
  task automatic run_layer(input bit relu, input bit hold, input bit pulse, input int rst_at);
    h_rd = '0; h_mac = '0; h_acc = '0; h_relu = '0; h_qdq = '0; h_rnd = '0;
    h_sat = '0; h_we = '0; h_done = '0; h_busy = '0; h_clr = '0; viol = 0;
    @(negedge clk);
    sample(0);
    bus.start_i    = 1'b1;
    bus.relu_cfg_i = relu;
    for (int idx = 1; idx <= 40; idx++) begin
      @(negedge clk);
      bus.relu_cfg_i = 1'b0;
      sample(idx);
      bus.start_i = hold || (pulse && (idx == 5 || idx == 20));
      if (idx == rst_at) begin
        #2 rstn = 1'b0;
        #1 chk("rst_mid_outs", outs(), 64'd0);
        break;
      end
    end
    bus.start_i = 1'b0;
  endtask

  task automatic check_timing(input bit relu);
    chk("rd_en",   h_rd,   rng(1, 4) | rng(14, 17));
    chk("mac_en",  h_mac,  rng(2, 5) | rng(15, 18));
    chk("acc_en",  h_acc,  rng(4, 7) | rng(17, 20));
    chk("relu_en", h_relu, relu ? (rng(8, 8) | rng(21, 21)) : 64'd0);
    chk("qdq_en",  h_qdq,  rng(9, 9) | rng(22, 22));
    chk("round",   h_rnd,  rng(11, 11) | rng(24, 24));
    chk("sat",     h_sat,  rng(12, 12) | rng(25, 25));
    chk("out_we",  h_we,   rng(13, 13) | rng(26, 26));
    chk("done",    h_done, rng(27, 27));
    chk("busy",    h_busy, rng(1, 27));
    chk("clear",   h_clr,  rng(1, 1) | rng(14, 14));
    chk("img_addr", 64'({ia[1], ia[2], ia[3], ia[4]}), 64'h0123);
    chk("w_addr",   64'({wa[14], wa[15], wa[16], wa[17]}), 64'h04050607);
    chk("out_addr", 64'({oa[13], oa[26]}), 64'h1);
    chk("exclusive", 64'(viol), 64'd0);
  endtask

  initial begin
    rstn = 1'b1;
    bus.start_i = 1'b0;
    bus.relu_cfg_i = 1'b0;
    for (int i = 0; i < 4; i++) img_mem[i] = 8'sd127;
    for (int i = 0; i < 8; i++) w_mem[i] = 8'sd127;

    #2 rstn = 1'b0;
    #1 chk("rst_async", outs(), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy_o), 64'd0);

    // relu=1, all-127 image and weights: both neurons produce 36
    run_layer(1'b1, 1'b0, 1'b0, 0);
    check_timing(1'b1);
    chk("e2e_127_n0", 64'({56'd0, omem[0]}), 64'd36);
    chk("e2e_127_n1", 64'({56'd0, omem[1]}), 64'd36);

    run_layer(1'b0, 1'b0, 1'b0, 0);
    check_timing(1'b0);

    run_layer(1'b1, 1'b0, 1'b1, 0);
    check_timing(1'b1);

    // start held through DONE: second layer begins at done+2
    run_layer(1'b1, 1'b1, 1'b0, 0);
    chk("hold_clear", h_clr,  rng(1, 1) | rng(14, 14) | rng(29, 29));
    chk("hold_busy",  h_busy, rng(1, 27) | rng(29, 40));
    chk("hold_done",  h_done, rng(27, 27));
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_layer(1'b1, 1'b0, 1'b0, 3);
    chk("rst_mid_done", h_done, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_layer(1'b1, 1'b0, 1'b0, 0);
    check_timing(1'b1);

    // neuron 1 weights negative: relu clamps it to 0, neuron 0 unaffected
    for (int i = 4; i < 8; i++) w_mem[i] = -8'sd1;
    run_layer(1'b1, 1'b0, 1'b0, 0);
    chk("e2e_mix_n0", 64'({56'd0, omem[0]}), 64'd36);
    chk("e2e_mix_n1", 64'({56'd0, omem[1]}), 64'd0);

    for (int i = 0; i < 8; i++) w_mem[i] = -8'sd1;
    run_layer(1'b1, 1'b0, 1'b0, 0);
    chk("e2e_neg_n0", 64'({56'd0, omem[0]}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
